// File: rtl/serial_add_wcarry_nbits.sv
// Bit-serial adder: one full-adder cell and a carry flop add two latched
// operands LSB first, then post sum, carry-out and signed overflow.
module serial_add_wcarry_nbits #(
    parameter int width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [width-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int CW = (width > 2) ? $clog2(width) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t            state_r;
    state_t            state_nx_s;
    logic              accept_s;
    logic [width-1:0]  a_sh_r;
    logic [width-1:0]  b_sh_r;
    logic [width-1:0]  res_r;
    logic              carry_r;
    logic              c_msb_r;
    logic [CW-1:0]     cnt_r;
    logic              sum_bit_s;
    logic              carry_nx_s;

    assign sum_bit_s  = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
    assign carry_nx_s = maj3(a_sh_r[0], b_sh_r[0], carry_r);

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a start in DONE is accepted exactly as from IDLE
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_nx_s = RUN;
                    accept_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (start_i) begin
                    state_nx_s = RUN;
                    accept_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                accept_s   = 1'b0;
            end
        endcase
    end

    // Operand shifters, carry flop, bit counter and result accumulator
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sh_r  <= {width{1'b0}};
            b_sh_r  <= {width{1'b0}};
            res_r   <= {width{1'b0}};
            carry_r <= 1'b0;
            c_msb_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else if (accept_s) begin
            a_sh_r  <= a_i;
            b_sh_r  <= b_i;
            carry_r <= cin_i;
            cnt_r   <= CNT_ZERO;
        end else if (state_r == RUN) begin
            a_sh_r  <= {1'b0, a_sh_r[width-1:1]};
            b_sh_r  <= {1'b0, b_sh_r[width-1:1]};
            res_r   <= {sum_bit_s, res_r[width-1:1]};
            carry_r <= carry_nx_s;
            cnt_r   <= cnt_r + CNT_ONE;
            // carry entering the MSB stage, kept for signed overflow
            if (cnt_r == CNT_LAST) begin
                c_msb_r <= carry_r;
            end
        end
    end

    // Registered outputs; results only move when leaving DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
            s_o    <= {width{1'b0}};
            cout_o <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            busy_o <= (state_nx_s == RUN);
            done_o <= (state_r == DONE);
            if (state_r == DONE) begin
                s_o    <= res_r;
                cout_o <= carry_r;
                ovf_o  <= c_msb_r ^ carry_r;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_wcarry_nbits.sv
// Directed and random checks of the bit-serial adder at width 8.
module tb_serial_add_wcarry_nbits;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       cin_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] s_o;
    logic       cout_o;
    logic       ovf_o;

    int n_pass  = 0;
    int n_total = 0;

    serial_add_wcarry_nbits #(.width(8)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(start_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .cin_i  (cin_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .s_o    (s_o),
        .cout_o (cout_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for done_o (bounded); returns edges after acceptance and busy samples seen
    task automatic wait_done(output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        do begin
            if (busy_o) busy_n++;
            tick();
            edges++;
        end while (!done_o && edges < 40);
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [7:0] es, input logic ec, input logic eo);
        int edges;
        int busy_n;
        a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        a_i = ~a; b_i = 8'h5A; cin_i = ~c;
        wait_done(edges, busy_n);
        check({tag, "_latency"}, edges, 9);
        check({tag, "_busy_cycles"}, busy_n, 8);
        check({tag, "_sum"}, {cout_o, s_o}, {ec, es});
        check({tag, "_ovf"}, ovf_o, eo);
        tick();
        check({tag, "_done_single"}, done_o, 1'b0);
    endtask

    initial begin
        int          edges;
        int          busy_n;
        int          extra_done;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rc;
        logic [8:0]  full;
        logic        rovf;
        logic [7:0]  t5_a [3];
        logic [7:0]  t5_b [3];
        logic [8:0]  t5_e [3];

        rst_i = 1'b1; start_i = 1'b0; a_i = 8'h00; b_i = 8'h00; cin_i = 1'b0;
        tick(); tick();
        check("reset_outputs", {busy_o, done_o, cout_o, ovf_o, s_o}, 12'h000);
        rst_i = 1'b0;
        tick();
        check("idle_no_busy", {busy_o, done_o}, 2'b00);

        // T1-T3 directed arithmetic
        do_op("t1_3c_0f",   8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
        do_op("t2_ff_01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("t2_7f_01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        check("hold_after_op", {cout_o, ovf_o, s_o}, {1'b0, 1'b1, 8'h80});
        do_op("t3_80_80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        do_op("t3_ff_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

        // T4: start pulse mid-RUN is ignored
        a_i = 8'h10; b_i = 8'h20; cin_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        check("t4_hold_during_run", {cout_o, s_o}, {1'b1, 8'h00});
        a_i = 8'hAA; b_i = 8'h55; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(edges, busy_n);
        check("t4_latency", edges + 3, 9);
        check("t4_sum", {cout_o, s_o}, 9'h030);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_o || busy_o) extra_done++;
        end
        check("t4_no_second_op", extra_done, 0);

        // T5: start held high, back-to-back with operands changed after each acceptance
        t5_a[0] = 8'h01; t5_b[0] = 8'h02; t5_e[0] = 9'h003;
        t5_a[1] = 8'h10; t5_b[1] = 8'h11; t5_e[1] = 9'h021;
        t5_a[2] = 8'hF0; t5_b[2] = 8'h20; t5_e[2] = 9'h110;
        a_i = t5_a[0]; b_i = t5_b[0]; cin_i = 1'b0; start_i = 1'b1;
        tick();
        a_i = t5_a[1]; b_i = t5_b[1];
        for (int k = 0; k < 3; k++) begin
            wait_done(edges, busy_n);
            check($sformatf("t5_period_%0d", k), edges, 9);
            check($sformatf("t5_sum_%0d", k), {cout_o, s_o}, t5_e[k]);
            if (k == 0) begin
                a_i = t5_a[2]; b_i = t5_b[2];
            end else if (k == 1) begin
                start_i = 1'b0; a_i = 8'hEE; b_i = 8'hEE;
            end
        end
        tick();
        check("t5_stops", {busy_o, done_o}, 2'b00);

        // T6: reset four cycles into RUN
        a_i = 8'h55; b_i = 8'h22; cin_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick(); tick(); tick();
        rst_i = 1'b1;
        #1;
        check("t6_reset_clears", {busy_o, done_o, cout_o, ovf_o, s_o}, 12'h000);
        tick();
        rst_i = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_o || busy_o) extra_done++;
        end
        check("t6_no_done", extra_done, 0);
        do_op("t6_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Random operands against an arithmetic model
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rc   = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            rovf = (ra[7] == rb[7]) && (full[7] != ra[7]);
            do_op($sformatf("rand_%0d", n), ra, rb, rc, full[7:0], full[8], rovf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
